// File: rtl/simon_pkg.sv
// simon_pkg: shared constants and types for the Simon input conditioning stage
package simon_pkg;
    localparam int N_BTN = 4;
    localparam int DEBOUNCE_MS_DEF = 10;
    typedef enum logic {DB_STABLE, DB_CHANGING} db_state_t;
    function automatic logic [1:0] enc_onehot(input logic [N_BTN-1:0] v);
        return {v[3] | v[2], v[3] | v[1]};
    endfunction
endpackage

// File: rtl/simon_debounce_ch.sv
// simon_debounce_ch: one button channel -- 2-FF synchroniser plus millisecond-tick debounce
module simon_debounce_ch
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic milli_tick,
    input  logic raw,
    output logic clean,
    output logic press,
    output logic rel
);
    localparam logic [7:0] DC_LAST = 8'(DEBOUNCE_MS - 1);
    logic s1, s2;
    logic [7:0] dc, dc_run;
    db_state_t state;
    assign dc_run = (state == DB_CHANGING) ? dc : 8'd0;
    // Synchronise, then accept a changed level only after DEBOUNCE_MS consecutive ticks of mismatch
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            clean <= 1'b0;
            press <= 1'b0;
            rel <= 1'b0;
            dc <= 8'd0;
            state <= DB_STABLE;
        end else begin
            s1 <= raw;
            s2 <= s1;
            press <= 1'b0;
            rel <= 1'b0;
            if (s2 == clean) begin
                state <= DB_STABLE;
                dc <= 8'd0;
            end else if (!milli_tick) begin
                state <= DB_CHANGING;
            end else if (dc_run == DC_LAST) begin
                clean <= s2;
                press <= s2;
                rel <= !s2;
                dc <= 8'd0;
                state <= DB_STABLE;
            end else begin
                dc <= dc_run + 8'd1;
                state <= DB_CHANGING;
            end
        end
    end
endmodule

// File: rtl/simon_btn_conditioner.sv
// simon_btn_conditioner: synchronise and debounce the Simon buttons, emit press/release events and a press code
module simon_btn_conditioner
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ticks_per_milli,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_evt,
    output logic             press_valid,
    output logic [1:0]       press_code,
    output logic             multi,
    output logic             milli_tick
);
    logic [15:0] pc, pc_last;
    logic wrap;
    assign pc_last = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    assign wrap = pc >= pc_last;
    // Millisecond prescaler; >= lets a lowered period take effect immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 16'd0;
            milli_tick <= 1'b0;
        end else begin
            pc <= wrap ? 16'd0 : pc + 16'd1;
            milli_tick <= wrap;
        end
    end
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        simon_debounce_ch #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .milli_tick(milli_tick),
            .raw       (btn_raw[i]),
            .clean     (btn_clean[i]),
            .press     (press[i]),
            .rel       (release_evt[i])
        );
    end
    // Single-press encoder and multi-button flag, one cycle behind the clean levels
    always_ff @(posedge clk) begin
        if (rst) begin
            press_valid <= 1'b0;
            press_code <= 2'd0;
            multi <= 1'b0;
        end else begin
            press_valid <= $onehot(press) && $onehot(btn_clean);
            if ($onehot(press) && $onehot(btn_clean)) press_code <= enc_onehot(press);
            multi <= $countones(btn_clean) > 1;
        end
    end
endmodule

// File: tb/tb_simon_btn_conditioner.sv
// tb_simon_btn_conditioner: scoreboard bench for the button conditioner (T=4 cycles/ms, 3 ms debounce)
module tb_simon_btn_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] ticks_per_milli = 16'd4;
    logic [3:0] btn_raw = 4'd0;
    logic [3:0] btn_clean, press, release_evt;
    logic press_valid, multi, milli_tick;
    logic [1:0] press_code;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    typedef struct {
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] cl;
        logic pv;
        logic [1:0] code;
        logic m;
        int lo;
        int hi;
    } exp_t;
    exp_t q[$];

    simon_btn_conditioner #(.DEBOUNCE_MS(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .ticks_per_milli(ticks_per_milli),
        .btn_raw        (btn_raw),
        .btn_clean      (btn_clean),
        .press          (press),
        .release_evt    (release_evt),
        .press_valid    (press_valid),
        .press_code     (press_code),
        .multi          (multi),
        .milli_tick     (milli_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected accept window: 2 sync cycles plus 9..12 cycles to the third tick
    task automatic expect_ev(input logic [3:0] p, input logic [3:0] r, input logic [3:0] cl,
                             input logic pv, input logic [1:0] code, input logic m);
        q.push_back('{p, r, cl, pv, code, m, cyc + 11, cyc + 14});
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 100) begin
            step(1);
            b++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected events never appeared", q.size());
            q.delete();
        end
        step(2);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_clean"}, int'(btn_clean), 0);
        chk({tag, "_press"}, int'(press), 0);
        chk({tag, "_release"}, int'(release_evt), 0);
        chk({tag, "_pv"}, int'(press_valid), 0);
        chk({tag, "_code"}, int'(press_code), 0);
        chk({tag, "_multi"}, int'(multi), 0);
        chk({tag, "_tick"}, int'(milli_tick), 0);
    endtask

    // Monitor: every press/release event pops one expectation; encoder outputs are checked a cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (press | release_evt) != 4'd0) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: press=%b release=%b clean=%b at cycle %0d", press, release_evt, btn_clean, cyc);
                end else begin
                    e = q.pop_front();
                    chk("ev_press", int'(press), int'(e.p));
                    chk("ev_release", int'(release_evt), int'(e.r));
                    chk("ev_clean", int'(btn_clean), int'(e.cl));
                    n_cmp++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        n_bad++;
                        $display("FAIL ev_latency: at cycle %0d expected within %0d..%0d", cyc, e.lo, e.hi);
                    end
                    @(negedge clk);
                    chk("ev_press_valid", int'(press_valid), int'(e.pv));
                    if (e.pv) chk("ev_press_code", int'(press_code), int'(e.code));
                    chk("ev_multi", int'(multi), int'(e.m));
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        step(3);
        chk_idle("reset");
        rst = 1'b0;
        step(3);
        // Clean press and release of channel 0
        btn_raw = 4'b0001;
        expect_ev(4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        drain();
        step(20);
        btn_raw = 4'b0000;
        expect_ev(4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        drain();
        // Short glitch on channel 2 must be rejected
        btn_raw = 4'b0100;
        step(6);
        btn_raw = 4'b0000;
        step(30);
        chk("glitch_clean", int'(btn_clean), 0);
        // Bouncing channel 1 settles high: one press only
        for (int i = 0; i < 8; i++) begin
            btn_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            step(3);
        end
        btn_raw = 4'b0010;
        expect_ev(4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
        drain();
        step(20);
        btn_raw = 4'b0000;
        expect_ev(4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0);
        drain();
        // Two buttons: second press is not a valid single press and raises multi
        btn_raw = 4'b0001;
        expect_ev(4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
        drain();
        btn_raw = 4'b1001;
        expect_ev(4'b1000, 4'b0000, 4'b1001, 1'b0, 2'd0, 1'b1);
        drain();
        btn_raw = 4'b1000;
        expect_ev(4'b0000, 4'b0001, 4'b1000, 1'b0, 2'd0, 1'b0);
        drain();
        btn_raw = 4'b0000;
        expect_ev(4'b0000, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0);
        drain();
        // Reset mid-debounce with channel 1 held: fresh press after a full interval
        btn_raw = 4'b0010;
        step(6);
        rst = 1'b1;
        step(2);
        chk_idle("midreset");
        rst = 1'b0;
        expect_ev(4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
        drain();
        btn_raw = 4'b0000;
        expect_ev(4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0);
        drain();
        // Prescaler: zero period ticks every cycle
        ticks_per_milli = 16'd0;
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk("tick_zero", int'(milli_tick), 1);
            step(1);
        end
        // Prescaler: lowering the period mid-count ticks on the next cycle
        ticks_per_milli = 16'd100;
        step(1);
        begin
            int b = 0;
            while (!milli_tick && b < 200) begin
                step(1);
                b++;
            end
            chk("tick_100_seen", int'(milli_tick), 1);
        end
        step(50);
        ticks_per_milli = 16'd4;
        step(1);
        chk("tick_after_lower", int'(milli_tick), 1);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("tick_period4", int'(milli_tick), (i % 4 == 0) ? 1 : 0);
        end
        chk("final_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/simon_btn_conditioner.md
# simon_btn_conditioner

Input conditioning stage that sits directly upstream of the Simon game core. It synchronises the four raw push-button inputs, debounces each one against a millisecond time base derived from `ticks_per_milli`, and drives clean button levels into the game's `btn` input. It also produces one-cycle press/release events and a one-hot press code for instrumentation or future consumers.

## Interface
- `N_BTN`, 4: number of button channels. Fixed at 4 for `press_code` encoding.
- `DEBOUNCE_MS`, 10: number of consecutive millisecond ticks a changed input must hold before it is accepted, range 1..255.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high. Clock is `clk`.
- `ticks_per_milli`  in  16: clock cycles per millisecond. Same value that is fed to the game core.
- `btn_raw`  in  N_BTN: asynchronous active-high button pins.
- `btn_clean`  out  N_BTN: debounced levels. Connects to the game core's `btn`.
- `press`  out  N_BTN: one-cycle pulse on each accepted 0→1 transition.
- `release`  out  N_BTN: one-cycle pulse on each accepted 1→0 transition.
- `press_valid`  out  1: one-cycle pulse when exactly one channel presses and `btn_clean` is one-hot after the update.
- `press_code`  out  2: index of the pressed channel. Valid only while `press_valid` is high; holds its last value otherwise.
- `multi`  out  1: registered flag, high while more than one `btn_clean` bit is set.
- `milli_tick`  out  1: one-cycle pulse once per millisecond.

## Operation
- **Synchroniser:** 2-FF chain per channel. Both stages reset to 0. `sync = stage2`.
- **Prescaler:** 16-bit counter `pc`.
  - When `pc >= ticks_per_milli - 1`: `pc <= 0` and `milli_tick` pulses.
  - Otherwise `pc <= pc + 1`.
  - `ticks_per_milli = 0` is treated as 1, so `milli_tick` pulses every cycle.
  - Using `>=` makes a lowered `ticks_per_milli` take effect without a full counter wrap.
- **Per-channel debounce:** 8-bit counter `dc`, two states.
  - **STABLE:** `sync == btn_clean[i]`, `dc = 0`. A mismatch moves the channel to CHANGING.
  - **CHANGING:**
    - If `sync == btn_clean[i]` on any cycle: return to STABLE and set `dc <= 0` (glitch rejected).
    - Otherwise, on each `milli_tick`: `dc <= dc + 1`.
    - When `dc == DEBOUNCE_MS - 1` and `milli_tick` is high: `btn_clean[i] <= sync`, `dc <= 0`, go to STABLE, and pulse `press[i]` or `release[i]` in the same cycle that `btn_clean` updates.
- **Press encoding:**
  - `press_valid` is registered from: popcount(`press`) == 1 and the next `btn_clean` is one-hot.
  - `press_code` is the binary index of that channel.
  - Simultaneous presses, or a press while another channel is already held, give no `press_valid` and `multi` goes high.
- **Reset values:** `btn_clean = 0`, `press = 0`, `release = 0`, `press_valid = 0`, `press_code = 0`, `multi = 0`, `milli_tick = 0`. All counters are 0 and all channels are STABLE.
- **Reset mid-operation:** all state clears. A button held through reset is reported as a fresh press after the full debounce interval.

## Timing
- Synchroniser latency: 2 cycles.
- Accept latency from a stable raw edge: 2 cycles plus the time to the DEBOUNCE_MS-th `milli_tick` after entering CHANGING. This is between (DEBOUNCE_MS-1)·T+1 and DEBOUNCE_MS·T cycles, with T = max(`ticks_per_milli`, 1).
- `btn_clean`, `press` and `release` change in the same cycle.
- `press_valid`, `press_code` and `multi` follow one cycle later.
- Every pulse output is high for exactly one cycle.
- No handshake: consumers sample the outputs every cycle.

## Structure
- Shared package `simon_pkg`:
  - `N_BTN`
  - default `DEBOUNCE_MS`
  - debounce state typedef: `DB_STABLE`, `DB_CHANGING`
- Sub-module `simon_debounce_ch`:
  - one channel: synchroniser, state, `dc`, `btn_clean` bit, press/release bits
  - instantiated N_BTN times
- The top level owns the prescaler, encoder and `multi` logic.

## Test plan
All scenarios use `ticks_per_milli = 4` and `DEBOUNCE_MS = 3`.
- **Clean press:** hold `btn_raw = 0001` for 40 cycles → `btn_clean = 0001` within 2+12 cycles. `press[0]` for 1 cycle. Next cycle `press_valid = 1`, `press_code = 0`. Release → `release[0]` pulse after the same latency.
- **Glitch:** `btn_raw[2]` high for 6 cycles, then low → `btn_clean` stays 0000. No `press` or `release` pulse.
- **Bounce:** toggle `btn_raw[1]` every 3 cycles for 24 cycles, then hold high → exactly one `press[1]`, accepted 2–3 ms after the last toggle.
- **Two buttons:** hold 0001, then add 1000 → `press[3]` pulses, `press_valid = 0`, `multi = 1`. Drop 0001 → `release[0]` pulses, `multi = 0`.
- **Prescaler:** `ticks_per_milli = 0` → `milli_tick` every cycle. Change from 100 to 4 while `pc = 50` → a tick on the next cycle, then every 4 cycles.
- **Reset mid-debounce:** assert `rst` while channel 1 is CHANGING with `btn_raw[1]` held → all outputs 0. After release of `rst`, `press[1]` pulses once, a full debounce interval later.
